// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM-stage load/store port.
// Takes one request at a time and holds it for LATENCY wait cycles.
// It then completes the request against a 64-bit word array and pulses
// mem_finish for one cycle.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   data_addr_i   request byte address (bits [2:0] ignored)
//   wmask_i       store byte enables, bit k -> data_i[8k+7:8k]
//   data_i        lane-aligned store data
//   we / re       store / load request (both high = store only)
//   data_o        last completed load word (0 for out-of-range load)
//   mem_finish    one-cycle completion pulse
//   access_err_o  high with mem_finish when the address is out of range

// Per-byte write merge: keeps the old byte unless its enable is set.
module dmem_lane (
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  input  logic       en,
  output logic [7:0] out_b
);
  assign out_b = en ? new_b : old_b;
endmodule

module dmem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_addr_i,
  input  logic [7:0]  wmask_i,
  input  logic [63:0] data_i,
  input  logic        we,
  input  logic        re,
  output logic [63:0] data_o,
  output logic        mem_finish,
  output logic        access_err_o
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]  cnt;
  logic [63:0] addr_q, wdata_q;
  logic [7:0]  wmask_q;
  logic        we_q, re_q;

  logic [63:0] mem [DEPTH];

  // In IDLE the live inputs are decoded so a zero-latency request can
  // register its load data on the same edge that captures it; in every
  // other state the captured request is decoded.
  logic [63:0] cur_addr, offset, rd_word, wr_word;
  logic        cur_we, cur_re, in_range;
  logic [AW-1:0] idx;

  assign cur_addr = (state == S_IDLE) ? data_addr_i : addr_q;
  assign cur_we   = (state == S_IDLE) ? we : we_q;
  assign cur_re   = (state == S_IDLE) ? re : re_q;
  assign offset   = cur_addr - BASE_ADDR;   // below BASE wraps to a huge value
  assign in_range = offset < SPAN;
  assign idx      = offset[AW+2:3];
  assign rd_word  = mem[idx];

  for (genvar k = 0; k < 8; k++) begin : g_lane
    dmem_lane u_lane (
      .old_b (rd_word[8*k +: 8]),
      .new_b (wdata_q[8*k +: 8]),
      .en    (wmask_q[k]),
      .out_b (wr_word[8*k +: 8])
    );
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (we | re) state_nxt = (LATENCY == 0) ? S_DONE : S_WAIT;
      S_WAIT: if (cnt <= 4'd1) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_finish   = (state == S_DONE);
    access_err_o = (state == S_DONE) && !in_range;
  end

  // Request capture and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (we | re) begin
          addr_q  <= data_addr_i;
          wdata_q <= data_i;
          wmask_q <= wmask_i;
          we_q    <= we;
          re_q    <= re;
          cnt     <= 4'(LATENCY);
        end
        S_WAIT:  cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Load data is taken on entry to DONE, so it reflects pre-store contents
  // and then holds until the next load completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o <= '0;
    end else if (state != S_DONE && state_nxt == S_DONE && cur_re && !cur_we) begin
      data_o <= in_range ? rd_word : 64'd0;
    end
  end

  // Store commits on the edge that ends DONE; a reset during WAIT/DONE
  // forces IDLE, so an abandoned store never reaches this point.
  always_ff @(posedge clk) begin
    if (state == S_DONE && we_q && in_range) mem[idx] <= wr_word;
  end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

  logic        clk = 1'b0, rst = 1'b0;
  logic [63:0] data_addr_i = '0, data_i = '0;
  logic [7:0]  wmask_i = '0;
  logic        we = 1'b0, re = 1'b0;
  logic [63:0] data_o;
  logic        mem_finish, access_err_o;

  always #5 clk = ~clk;

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .data_addr_i(data_addr_i), .wmask_i(wmask_i),
    .data_i(data_i), .we(we), .re(re), .data_o(data_o),
    .mem_finish(mem_finish), .access_err_o(access_err_o)
  );

  typedef struct { logic err; logic [63:0] data; } exp_t;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] model [longint];     // word index -> contents
  logic [63:0] last_load = '0;      // what data_o should be holding
  int          checks = 0, errors = 0;
  longint      cyc = 0;
  logic        prev_fin = 1'b0;
  longint      known [8] = '{0, 1, 2, 3, 100, 2047, 4094, 4095};
  logic [63:0] bad_addr [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_finish) begin
        chk("finish_one_cycle", {63'd0, prev_fin}, 64'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_finish: got mem_finish=1 expected no completion (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("access_err", {63'd0, access_err_o}, {63'd0, mon_e.err});
          chk("data_o", data_o, mon_e.data);
        end
      end else if (access_err_o) begin
        checks++; errors++;
        $display("FAIL err_without_finish: got access_err_o=1 expected 0 (cycle %0d)", cyc);
      end
    end
    prev_fin = mem_finish;
  end

  // Issue one request, update the reference model, wait for completion.
  task automatic do_req(input logic w, input logic r, input logic [63:0] a,
                        input logic [7:0] m, input logic [63:0] d, output longint fin_cyc);
    exp_t e; logic err; longint wi; logic [63:0] t; int n;
    err = (a < BASE) || (a >= LIMIT);
    wi  = longint'((a - BASE) >> 3);
    if (w) begin
      if (!err) begin
        t = model[wi];
        for (int k = 0; k < 8; k++) if (m[k]) t[8*k +: 8] = d[8*k +: 8];
        model[wi] = t;
      end
    end else if (r) begin
      last_load = err ? 64'd0 : model[wi];
    end
    e.err = err; e.data = last_load;
    exp_q.push_back(e);
    @(negedge clk);
    we = w; re = r; data_addr_i = a; wmask_i = m; data_i = d;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (mem_finish) break;
    end
    chk("latency", 64'(n), 64'(LAT + 1));
    fin_cyc = cyc;
    we = 1'b0; re = 1'b0;
  endtask

  function automatic logic [63:0] waddr(input longint wi);
    return BASE + 64'(wi) * 64'd8;
  endfunction

  initial begin
    longint f0, f1;
    logic [63:0] old_w;
    bad_addr = '{BASE - 64'd8, BASE - 64'd1, LIMIT, LIMIT + 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8};

    // Reset values without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_data_o", data_o, 64'd0);
    chk("rst_finish", {63'd0, mem_finish}, 64'd0);
    chk("rst_err", {63'd0, access_err_o}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Give every tracked word known contents
    foreach (known[i]) do_req(1, 0, waddr(known[i]), 8'hFF, {$urandom, $urandom}, f0);

    // Full store then load at 0x8000_0010
    do_req(1, 0, 64'h8000_0010, 8'hFF, 64'h1122334455667788, f0);
    do_req(0, 1, 64'h8000_0010, 8'h00, 64'd0, f0);
    chk("t2_model", last_load, 64'h1122334455667788);
    // Byte store in lane 2, reload
    do_req(1, 0, 64'h8000_0012, 8'h04, 64'h0000_0000_00AB_0000, f0);
    do_req(0, 1, 64'h8000_0010, 8'h00, 64'd0, f0);
    chk("t3_model", last_load, 64'h1122334455AB7788);
    // Out of range load and store; word 0 must be untouched
    do_req(0, 1, 64'h7FFF_FFF8, 8'h00, 64'd0, f0);
    do_req(1, 0, LIMIT, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, f0);
    do_req(0, 1, waddr(0), 8'h00, 64'd0, f0);
    do_req(1, 0, waddr(5), 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, f0);  // wmask=0: no change anywhere

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [63:0] a; int op;
      if ($urandom_range(0, 9) < 2) a = bad_addr[$urandom_range(0, 5)];
      else a = waddr(known[$urandom_range(0, 7)]) + 64'($urandom_range(0, 7));
      op = $urandom_range(0, 3);
      do_req(op == 0 || op == 2, op != 0, a, 8'($urandom), {$urandom, $urandom}, f0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Back-to-back store then load to the same word
    do_req(1, 0, waddr(3), 8'hFF, 64'hA5A5_0123_4567_5A5A, f0);
    do_req(0, 1, waddr(3), 8'h00, 64'd0, f1);
    chk("b2b_gap", 64'(f1 - f0), 64'(LAT + 2));
    chk("b2b_model", last_load, 64'hA5A5_0123_4567_5A5A);

    // Reset during WAIT of a full store: abandoned, old contents survive
    old_w = model[100];
    do_req(0, 1, waddr(4095), 8'h00, 64'd0, f0);
    @(negedge clk);
    we = 1'b1; re = 1'b0; data_addr_i = waddr(100); wmask_i = 8'hFF; data_i = ~old_w;
    @(negedge clk);
    we = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_data_o", data_o, 64'd0);
    chk("midrst_finish", {63'd0, mem_finish}, 64'd0);
    chk("midrst_err", {63'd0, access_err_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_load = 64'd0;
    repeat (6) @(negedge clk);
    do_req(0, 1, waddr(100), 8'h00, 64'd0, f0);
    chk("midrst_old", last_load, old_w);

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
